mux_n_pipe: RTL and testbench



---
 rtl/mux_pkg.sv | 28 ++
 rtl/mux_n.sv | 20 ++
 rtl/mux_n_pipe.sv | 110 +++++++++++
 tb/tb_mux_n_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared helpers for the N-way word selector family.
package mux_pkg;

    localparam int MUX_MAX_IN = 16;
    // Widest lane the extract helper can carry.
    localparam int MUX_MAX_W  = 64;
    localparam int MUX_MAX_VW = MUX_MAX_IN * MUX_MAX_W;

    // Ceiling log2, never below 1 so a select port always has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Lane idx of a packed vector of w-bit lanes; caller truncates to its width.
    function automatic logic [MUX_MAX_W-1:0] lane_extract(
        input int unsigned             idx,
        input int unsigned             w,
        input logic [MUX_MAX_VW-1:0]   v
    );
        return MUX_MAX_W'(v >> (idx * w));
    endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational NUM_IN x WIDTH word selector; out-of-range selects give zero.
module mux_n
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 11,
    parameter  int NUM_IN = 3,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] din_i,
    input  logic [SEL_W-1:0]        sel_i,
    output logic [WIDTH-1:0]        dout_o
);

    always_comb begin
        dout_o = '0;
        if (int'(sel_i) < NUM_IN)
            dout_o = WIDTH'(lane_extract(int'(sel_i), WIDTH, MUX_MAX_VW'(din_i)));
    end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-way word selector behind valid/ready with a 2-entry skid buffer.
// Define MUX_N_PIPE_SEL_ERR_EN to add a sel_err flag that travels with each word.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 11,
    parameter  int NUM_IN = 3,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        dout,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_N_PIPE_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    logic [WIDTH-1:0] sel_word;
    logic             accept, handoff;
    logic             ovld_q, ovld_d, svld_q, svld_d;
    logic [WIDTH-1:0] odat_q, odat_d, sdat_q, sdat_d;
`ifdef MUX_N_PIPE_SEL_ERR_EN
    logic             in_err;
    logic             oerr_q, oerr_d, serr_q, serr_d;
    assign in_err = (int'(sel) >= NUM_IN);
`endif

    mux_n #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_mux (
        .din_i  (din),
        .sel_i  (sel),
        .dout_o (sel_word)
    );

    // in_ready comes straight from the skid flag so upstream sees no out_ready path.
    assign in_ready = !svld_q;
    assign accept   = in_valid && !svld_q;
    assign handoff  = ovld_q && out_ready;

    always_comb begin
        ovld_d = ovld_q;
        odat_d = odat_q;
        svld_d = svld_q;
        sdat_d = sdat_q;
`ifdef MUX_N_PIPE_SEL_ERR_EN
        oerr_d = oerr_q;
        serr_d = serr_q;
`endif
        if (!ovld_q || handoff) begin
            if (svld_q) begin
                ovld_d = 1'b1;
                odat_d = sdat_q;
                svld_d = 1'b0;
`ifdef MUX_N_PIPE_SEL_ERR_EN
                oerr_d = serr_q;
`endif
            end else if (accept) begin
                ovld_d = 1'b1;
                odat_d = sel_word;
`ifdef MUX_N_PIPE_SEL_ERR_EN
                oerr_d = in_err;
`endif
            end else begin
                // dout keeps its last value; only the valid flag drops.
                ovld_d = 1'b0;
            end
        end else if (accept) begin
            svld_d = 1'b1;
            sdat_d = sel_word;
`ifdef MUX_N_PIPE_SEL_ERR_EN
            serr_d = in_err;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovld_q <= 1'b0;
            odat_q <= '0;
            svld_q <= 1'b0;
            sdat_q <= '0;
`ifdef MUX_N_PIPE_SEL_ERR_EN
            oerr_q <= 1'b0;
            serr_q <= 1'b0;
`endif
        end else begin
            ovld_q <= ovld_d;
            odat_q <= odat_d;
            svld_q <= svld_d;
            sdat_q <= sdat_d;
`ifdef MUX_N_PIPE_SEL_ERR_EN
            oerr_q <= oerr_d;
            serr_q <= serr_d;
`endif
        end
    end

    assign dout      = odat_q;
    assign out_valid = ovld_q;
`ifdef MUX_N_PIPE_SEL_ERR_EN
    assign sel_err   = oerr_q;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench: default 11x3 instance for directed/random traffic, 16x5 for streaming.
module tb_mux_n_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    // Instance A: WIDTH=11, NUM_IN=3
    logic [10:0] a_lane [3];
    logic [32:0] a_din;
    logic [1:0]  a_sel = '0;
    logic        a_iv = 1'b0, a_or = 1'b0;
    logic        a_ir, a_ov;
    logic [10:0] a_dout;
    logic        a_err;
    assign a_din = {a_lane[2], a_lane[1], a_lane[0]};

    // Instance B: WIDTH=16, NUM_IN=5
    logic [15:0] b_lane [5];
    logic [79:0] b_din;
    logic [2:0]  b_sel = '0;
    logic        b_iv = 1'b0, b_or = 1'b0;
    logic        b_ir, b_ov;
    logic [15:0] b_dout;
    logic        b_err;
    assign b_din = {b_lane[4], b_lane[3], b_lane[2], b_lane[1], b_lane[0]};

`ifndef MUX_N_PIPE_SEL_ERR_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    mux_n_pipe dut_a (
        .clk(clk), .reset(reset), .din(a_din), .sel(a_sel),
        .in_valid(a_iv), .in_ready(a_ir), .dout(a_dout),
        .out_valid(a_ov), .out_ready(a_or)
`ifdef MUX_N_PIPE_SEL_ERR_EN
        , .sel_err(a_err)
`endif
    );

    mux_n_pipe #(.WIDTH(16), .NUM_IN(5)) dut_b (
        .clk(clk), .reset(reset), .din(b_din), .sel(b_sel),
        .in_valid(b_iv), .in_ready(b_ir), .dout(b_dout),
        .out_valid(b_ov), .out_ready(b_or)
`ifdef MUX_N_PIPE_SEL_ERR_EN
        , .sel_err(b_err)
`endif
    );

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected entries are {sel_err, word}.
    function automatic logic [11:0] a_model();
        if (a_sel < 2'd3) return {1'b0, a_lane[a_sel]};
        return {1'b1, 11'h0};
    endfunction

    function automatic logic [16:0] b_model();
        if (b_sel < 3'd5) return {1'b0, b_lane[b_sel]};
        return {1'b1, 16'h0};
    endfunction

    logic [11:0] qa[$];
    logic [16:0] qb[$];
    bit          a_stall = 1'b0;
    logic [10:0] a_prev = '0;
    int          b_acc = 0, b_hs = 0;

    always @(negedge clk) begin
        bit acc, hs;
        chk("a_in_ready", 32'(a_ir), 32'(qa.size() < 2));
        chk("a_out_valid", 32'(a_ov), 32'(qa.size() > 0));
        if (qa.size() > 0) begin
            chk("a_dout", 32'(a_dout), 32'(qa[0][10:0]));
`ifdef MUX_N_PIPE_SEL_ERR_EN
            chk("a_sel_err", 32'(a_err), 32'(qa[0][11]));
`endif
        end
        if (a_stall) chk("a_stable", 32'(a_dout), 32'(a_prev));
        if (reset) begin
            qa.delete();
            a_stall = 1'b0;
        end else begin
            acc = a_iv && (qa.size() < 2);
            hs  = (qa.size() > 0) && a_or;
            a_stall = (qa.size() > 0) && !a_or;
            a_prev  = a_dout;
            if (hs) void'(qa.pop_front());
            if (acc) qa.push_back(a_model());
        end
    end

    always @(negedge clk) begin
        bit acc, hs;
        chk("b_in_ready", 32'(b_ir), 32'(qb.size() < 2));
        chk("b_out_valid", 32'(b_ov), 32'(qb.size() > 0));
        if (qb.size() > 0) begin
            chk("b_dout", 32'(b_dout), 32'(qb[0][15:0]));
`ifdef MUX_N_PIPE_SEL_ERR_EN
            chk("b_sel_err", 32'(b_err), 32'(qb[0][16]));
`endif
        end
        if (reset) begin
            qb.delete();
        end else begin
            if (b_iv && b_ir) b_acc++;
            if (b_ov && b_or) b_hs++;
            acc = b_iv && (qb.size() < 2);
            hs  = (qb.size() > 0) && b_or;
            if (hs) void'(qb.pop_front());
            if (acc) qb.push_back(b_model());
        end
    end

    initial begin
        a_lane[0] = 11'h7FF; a_lane[1] = 11'h155; a_lane[2] = 11'h2AA;
        for (int i = 0; i < 5; i++) b_lane[i] = '0;

        repeat (3) tick();
        chk("rst_in_ready", 32'(a_ir), 32'd1);
        chk("rst_out_valid", 32'(a_ov), 32'd0);
        chk("rst_dout", 32'(a_dout), 32'd0);
        reset = 1'b0;

        // First word, one-cycle latency
        a_sel = 2'd1; a_iv = 1'b1; a_or = 1'b1;
        tick();
        a_iv = 1'b0;
        chk("first_valid", 32'(a_ov), 32'd1);
        chk("first_dout", 32'(a_dout), 32'h155);
        tick();

        // Back-pressure fills OREG then SREG
        a_or = 1'b0; a_sel = 2'd0; a_iv = 1'b1;
        tick();
        a_sel = 2'd2;
        tick();
        a_iv = 1'b0;
        chk("bp_dout", 32'(a_dout), 32'h7FF);
        chk("bp_in_ready", 32'(a_ir), 32'd0);
        repeat (2) tick();
        chk("bp_hold", 32'(a_dout), 32'h7FF);
        a_or = 1'b1;
        tick();
        chk("bp_second", 32'(a_dout), 32'h2AA);
        chk("bp_second_valid", 32'(a_ov), 32'd1);
        tick();
        chk("bp_empty", 32'(a_ov), 32'd0);

        // Out-of-range select
        a_sel = 2'd3; a_iv = 1'b1;
        tick();
        a_iv = 1'b0;
        chk("oor_dout", 32'(a_dout), 32'd0);
        chk("oor_valid", 32'(a_ov), 32'd1);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        chk("oor_err", 32'(a_err), 32'd1);
`endif
        a_sel = 2'd0; a_iv = 1'b1;
        tick();
        a_iv = 1'b0;
        chk("inr_dout", 32'(a_dout), 32'h7FF);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        chk("inr_err", 32'(a_err), 32'd0);
`endif
        tick();

        // Reset with both registers full and in_valid high
        a_or = 1'b0; a_sel = 2'd0; a_iv = 1'b1;
        tick();
        a_sel = 2'd1;
        tick();
        chk("full_in_ready", 32'(a_ir), 32'd0);
        reset = 1'b1; a_sel = 2'd2;
        tick();
        reset = 1'b0; a_iv = 1'b0;
        chk("rmid_valid", 32'(a_ov), 32'd0);
        chk("rmid_in_ready", 32'(a_ir), 32'd1);
        a_or = 1'b1;
        tick();
        chk("rmid_no_stale", 32'(a_ov), 32'd0);

        // Random valid/ready traffic
        for (int i = 0; i < 1000; i++) begin
            a_iv = 1'($urandom_range(0, 1));
            a_or = 1'($urandom_range(0, 1));
            a_sel = 2'($urandom_range(0, 3));
            for (int j = 0; j < 3; j++) a_lane[j] = 11'($urandom);
            tick();
        end
        a_iv = 1'b0; a_or = 1'b1;
        repeat (3) tick();
        chk("rand_drained", 32'(a_ov), 32'd0);

        // Streaming on the 16x5 instance
        b_or = 1'b1;
        for (int i = 0; i < 100; i++) begin
            b_iv = 1'b1;
            b_sel = 3'($urandom_range(0, 7));
            for (int j = 0; j < 5; j++) b_lane[j] = 16'($urandom);
            tick();
        end
        b_iv = 1'b0;
        repeat (3) tick();
        chk("stream_accepts", 32'(b_acc), 32'd100);
        chk("stream_outputs", 32'(b_hs), 32'd100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
